// File: rtl/micro_pkg.sv
// Shared definitions for the micro core: phase bit positions,
// opcode field location, halt opcode default and the phase vector type.
package micro_pkg;

  localparam int F = 4;
  localparam int R = 3;
  localparam int X = 2;
  localparam int M = 1;
  localparam int W = 0;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;

  localparam logic [5:0] HLT_OP_DEF = 6'h3F;

  typedef logic [4:0] phase_t;

  function automatic logic is_onehot(input phase_t p);
    return $onehot(p);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus between fetch_unit and its neighbours (phase_gen, memory, alu).
// The retired port exists only when FETCH_PERF_EN is defined.
interface fetch_unit_if
  import micro_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int MA_W = 8
);

  phase_t            phase;
  logic              ct_taken;
  logic [PC_W-1:0]   dr;
  logic [31:0]       md_out;
  logic [PC_W-1:0]   pc;
  logic [MA_W-1:0]   ma;
  logic [31:0]       ir;
  logic              hlt;
`ifdef FETCH_PERF_EN
  logic [31:0]       retired;
`endif

`ifdef FETCH_PERF_EN
  modport master (
    input  phase, ct_taken, dr, md_out,
    output pc, ma, ir, hlt, retired
  );
  modport slave (
    output phase, ct_taken, dr, md_out,
    input  pc, ma, ir, hlt, retired
  );
`else
  modport master (
    input  phase, ct_taken, dr, md_out,
    output pc, ma, ir, hlt
  );
  modport slave (
    output phase, ct_taken, dr, md_out,
    input  pc, ma, ir, hlt
  );
`endif

endinterface

// File: rtl/fetch_unit_retire_counter.sv
// Free-running 32-bit retired-instruction counter.
// Counts one per enabled edge and wraps at 2^32.
module retire_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  // count enabled edges; async reset clears
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// PC / instruction-fetch stage of the micro multi-cycle core.
// Define FETCH_PERF_EN to add the retired-instruction counter.
module fetch_unit
  import micro_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              MA_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [5:0]      HLT_OP   = HLT_OP_DEF
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_ir;
  logic            r_hlt;

  logic            w_legal;
  logic            w_f;
  logic            w_r;
  logic            w_m;
  logic            w_w;
  logic            w_is_hlt;
  logic [PC_W-1:0] w_pc_nxt;
  logic [MA_W-1:0] w_ma;

  // illegal phase vectors decode to no phase at all
  assign w_legal  = is_onehot(bus.phase);
  assign w_f      = w_legal & bus.phase[F];
  assign w_r      = w_legal & bus.phase[R];
  assign w_m      = w_legal & bus.phase[M];
  assign w_w      = w_legal & bus.phase[W];
  assign w_is_hlt = (r_ir[OP_HI:OP_LO] == HLT_OP);
  assign w_pc_nxt = bus.ct_taken ? bus.dr
                                 : r_pc + PC_W'(1);

  // memory address: data address in m, PC otherwise
  always_comb begin
    w_ma = r_pc[MA_W-1:0];
    if (w_m) begin
      w_ma = bus.dr[MA_W-1:0];
    end
  end

  // architectural state; frozen once halted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc  <= RESET_PC;
      r_ir  <= '0;
      r_hlt <= 1'b0;
    end else if (!r_hlt) begin
      unique case (1'b1)
        w_f: r_ir <= bus.md_out;
        w_r: if (w_is_hlt) r_hlt <= 1'b1;
        w_w: r_pc <= w_pc_nxt;
        default: ;
      endcase
    end
  end

  assign bus.pc  = r_pc;
  assign bus.ma  = w_ma;
  assign bus.ir  = r_ir;
  assign bus.hlt = r_hlt;

`ifdef FETCH_PERF_EN
  logic        w_ret_en;
  logic [31:0] w_retired;

  assign w_ret_en = w_w & ~r_hlt;

  retire_counter u_retire (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_ret_en),
    .o_count (w_retired)
  );

  assign bus.retired = w_retired;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus
// randomized phase/branch/halt/reset traffic against an ISA-level model.
module tb_fetch_unit;
  import micro_pkg::*;

  localparam logic [4:0] PF = 5'b10000;
  localparam logic [4:0] PR = 5'b01000;
  localparam logic [4:0] PX = 5'b00100;
  localparam logic [4:0] PM = 5'b00010;
  localparam logic [4:0] PW = 5'b00001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.PC_W(32), .MA_W(8)) bus ();

  fetch_unit #(
    .PC_W     (32),
    .MA_W     (8),
    .RESET_PC (32'h0),
    .HLT_OP   (6'h3F)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [256];
  assign bus.md_out = mem[bus.ma];

  int tot = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [31:0] m_ret;
  logic        m_hlt;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // instruction-level model: what each completed phase does to the machine
  always @(posedge clk) begin
    if (rst === 1'b1 && !m_hlt && $countones(bus.phase) == 1) begin
      if (bus.phase == PF) begin
        m_ir = mem[m_pc[7:0]];
      end else if (bus.phase == PR) begin
        if (m_ir[31:26] == 6'h3F) m_hlt = 1'b1;
      end else if (bus.phase == PW) begin
        m_pc  = bus.ct_taken ? bus.dr : m_pc + 32'd1;
        m_ret = m_ret + 32'd1;
      end
    end
  end

  // compare DUT to model mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      logic [7:0] exp_ma;
      exp_ma = (bus.phase == PM) ? bus.dr[7:0] : m_pc[7:0];
      chk("pc", bus.pc, m_pc);
      chk("ir", bus.ir, m_ir);
      chk("hlt", {31'b0, bus.hlt}, {31'b0, m_hlt});
      chk("ma", {24'b0, bus.ma}, {24'b0, exp_ma});
`ifdef FETCH_PERF_EN
      chk("retired", bus.retired, m_ret);
`endif
    end
  end

  task automatic model_reset();
    m_pc  = 32'h0;
    m_ir  = 32'h0;
    m_hlt = 1'b0;
    m_ret = 32'h0;
  endtask

  task automatic do_reset();
    model_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic step(logic [4:0] ph, bit ct, logic [31:0] d);
    bus.phase    = ph;
    bus.ct_taken = ct;
    bus.dr       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic instr(bit ct, logic [31:0] dw, logic [31:0] dm);
    step(PF, 1'($urandom), $urandom);
    step(PR, 1'($urandom), $urandom);
    step(PX, 1'($urandom), $urandom);
    step(PM, 1'($urandom), dm);
    step(PW, ct, dw);
  endtask

  initial begin
    logic [4:0]  seq [5];
    logic [4:0]  ph;
    logic [31:0] wd;
    int          k;
    seq[0] = PF; seq[1] = PR; seq[2] = PX; seq[3] = PM; seq[4] = PW;

    bus.phase    = 5'b0;
    bus.ct_taken = 1'b0;
    bus.dr       = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h04000001;
    mem[1] = 32'h04000002;
    mem[2] = 32'h04000003;
    mem[3] = 32'hFC000000;
    model_reset();
    chk_en = 1'b1;
    do_reset();

    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_ir", bus.ir, 32'h0);
    chk("rst_hlt", {31'b0, bus.hlt}, 32'h0);

    // sequential fetch
    for (int i = 0; i < 3; i++) begin
      bus.phase = PF;
      #1;
      chk("seq_ma", {24'b0, bus.ma}, i);
      instr(1'b0, $urandom, $urandom);
      chk("seq_pc", bus.pc, i + 1);
      chk("seq_ir", bus.ir, 32'h04000001 + i);
    end

    // halt at pc=3
    step(PF, 1'b0, 32'h0);
    chk("hlt_ir", bus.ir, 32'hFC000000);
    chk("hlt_pre", {31'b0, bus.hlt}, 32'h0);
    step(PR, 1'b0, 32'h0);
    chk("hlt_rise", {31'b0, bus.hlt}, 32'h1);
    step(PX, 1'b0, 32'h0);
    step(PM, 1'b0, 32'h55);
    step(PW, 1'b1, 32'h99);
    repeat (3) instr(1'b1, 32'h77, 32'h12);
    chk("hlt_pc", bus.pc, 32'h3);
    chk("hlt_hold", {31'b0, bus.hlt}, 32'h1);
    chk("hlt_irh", bus.ir, 32'hFC000000);
`ifdef FETCH_PERF_EN
    chk("hlt_ret", bus.retired, 32'h3);
`endif

    // asynchronous reset during x with pc=5
    mem[3] = 32'h0;
    mem[5] = 32'h12345678;
    do_reset();
    repeat (5) instr(1'b0, $urandom, $urandom);
    chk("pre_rst_pc", bus.pc, 32'h5);
    step(PF, 1'b0, 32'h0);
    step(PR, 1'b0, 32'h0);
    bus.phase = PX;
    #2;
    model_reset();
    rst = 1'b0;
    #1;
    chk("async_pc", bus.pc, 32'h0);
    chk("async_ir", bus.ir, 32'h0);
    chk("async_hlt", {31'b0, bus.hlt}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    // branch and m-phase data address
    step(PF, 1'b1, 32'h0);
    step(PR, 1'b1, 32'h0);
    step(PX, 1'b1, 32'h0);
    bus.phase = PM;
    bus.dr    = 32'h1A7;
    #1;
    chk("m_ma", {24'b0, bus.ma}, 32'hA7);
    step(PM, 1'b0, 32'h1A7);
    step(PW, 1'b1, 32'h40);
    chk("br_pc", bus.pc, 32'h40);
    bus.phase = PF;
    #1;
    chk("br_ma", {24'b0, bus.ma}, 32'h40);

    // wrap at 2^32
    mem[8'hFF] = 32'h0ABCDEF0;
    instr(1'b1, 32'hFFFFFFFF, 32'h3);
    chk("wrap_pre", bus.pc, 32'hFFFFFFFF);
    instr(1'b0, $urandom, $urandom);
    chk("wrap_pc", bus.pc, 32'h0);
    chk("wrap_ir", bus.ir, 32'h0ABCDEF0);

    // illegal phase vectors
    repeat (3) step(5'b00000, 1'b1, $urandom);
    repeat (3) step(5'b10001, 1'b1, $urandom);
    chk("ill_pc", bus.pc, 32'h0);
    chk("ill_ir", bus.ir, 32'h0ABCDEF0);

    // randomized traffic
    for (int i = 0; i < 256; i++) begin
      wd = $urandom;
      if ($urandom_range(7) == 0) wd[31:26] = 6'h3F;
      else if (wd[31:26] == 6'h3F) wd[31:26] = 6'h01;
      mem[i] = wd;
    end
    do_reset();
    k = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(199) == 0 ||
          (m_hlt && $urandom_range(15) == 0)) begin
        do_reset();
        k = 0;
      end
      if ($urandom_range(9) == 0) begin
        ph = 5'($urandom);
      end else begin
        ph = seq[k % 5];
        k++;
      end
      wd = ($urandom_range(3) == 0) ? 32'($urandom_range(255)) : $urandom;
      step(ph, 1'($urandom), wd);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and instruction-fetch stage of the `micro` multi-cycle core. It holds the 32-bit PC and drives the memory address (`ma`). It captures the fetched word into the instruction register (`ir`) and advances or redirects the PC once per instruction under control of the one-hot phase vector from `phase_gen`. It also detects the halt opcode and raises `hlt` back to `phase_gen`, so it sits directly upstream of `memory` (address source) and `alu`/`register_file` (instruction consumer).

## Interface
Parameters:
- `PC_W`, 32, PC and `dr` width
- `MA_W`, 8, memory address width (word address)
- `RESET_PC`, 32'h0, PC value after reset
- `HLT_OP`, 6'h3F, opcode in `ir[31:26]` that halts the core

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `phase`  in  5  one-hot phase: bit 4 = f, 3 = r, 2 = x, 1 = m, 0 = w
- `ct_taken`  in  1  control transfer taken; sampled in w
- `dr`  in  PC_W  ALU result: branch target in w, data address in m
- `md_out`  in  32  memory read data; combinational w.r.t. `ma`
- `pc`  out  PC_W  current PC
- `ma`  out  MA_W  memory address
- `ir`  out  32  instruction register
- `hlt`  out  1  sticky halt request to `phase_gen`
- `retired`  out  32  retired-instruction count; present only with `FETCH_PERF_EN`

## Operation
- Reset (`rst`=0, any time, including mid-instruction):
  - `pc`=RESET_PC, `ir`=0, `hlt`=0, `retired`=0.
  - `ma` follows the combinational rule below.
- `ma` is combinational:
  - phase f: `pc[MA_W-1:0]`
  - phase m: `dr[MA_W-1:0]`
  - otherwise: `pc[MA_W-1:0]`
- Edge ending f: `ir` <= `md_out`.
- Edge ending r: if `ir[31:26]`==HLT_OP then `hlt` <= 1.
- Edge ending w:
  - `pc` <= `ct_taken` ? `dr` : `pc`+1.
  - Arithmetic is modulo 2^PC_W; 32'hFFFFFFFF+1 wraps to 0.
- Halt:
  - Once `hlt`=1 it stays 1 until reset.
  - While `hlt`=1, `pc`, `ir` and `retired` hold regardless of `phase`; `ma` still follows the rule above.
  - The HLT instruction never reaches w, so it is not retired.
- Illegal phase (zero or more than one bit set): no register updates; `ma`=`pc[MA_W-1:0]`.
- `ct_taken` is ignored outside w. `dr` affects only `ma` (in m) and the PC load (in w).

## Timing
- One phase per `clk`; one instruction takes 5 cycles (f→r→x→m→w).
- `ir` is valid from the cycle after f through the next f.
- `hlt` is registered and rises in the cycle after r of the HLT instruction; `phase_gen` must stop within that cycle.
- New `pc` is visible in the cycle after w, which is the next f; the fetch therefore uses the updated PC with zero bubble.
- Address-to-data path: `ma`→`md_out`→`ir` D input is one combinational path within the f cycle.

## Configuration
- Macro: `FETCH_PERF_EN`.
- Defined:
  - Adds the `retired` output and a 32-bit counter.
  - The counter increments at each edge ending w while `hlt`=0 and wraps at 2^32.
  - Reset value is 0.
- Undefined: no `retired` port and no counter logic; all other behaviour is identical.

## Structure
- The shared package `micro_pkg` holds:
  - phase bit indices `F`=4, `R`=3, `X`=2, `M`=1, `W`=0
  - opcode field position `OP_HI`=31, `OP_LO`=26
  - `HLT_OP` default
  - phase vector typedef `phase_t` (5-bit)
- One sub-module is natural: `retire_counter` (counter plus enable), instantiated only under `FETCH_PERF_EN`.

## Test plan
- Reset mid-run: assert `rst`=0 during phase x with `pc`=5 → `pc`=0, `ir`=0, `hlt`=0 immediately, without waiting for a clock edge.
- Sequential fetch:
  - Stimulus: memory words 0..2 = 32'h04000001, 32'h04000002, 32'h04000003; `ct_taken`=0; run 3 instructions.
  - Required: `ir` takes each value after its f; `pc` reads 1, 2, 3 after each w; `ma`=`pc` during f.
- Branch:
  - Stimulus: in w assert `ct_taken`=1 with `dr`=32'h40.
  - Required: next f has `pc`=32'h40 and `ma`=8'h40.
  - Also: in phase m with `dr`=32'h1A7, `ma`=8'hA7.
- Halt:
  - Stimulus: word at `pc`=3 is 32'hFC000000.
  - Required: `hlt`=1 one cycle after r; `pc` stays 3; `retired`=3 with the macro; further phase activity changes nothing.
- Wrap and illegal phase:
  - `pc`=32'hFFFFFFFF, w with `ct_taken`=0 → `pc`=0.
  - `phase`=5'b00000 or 5'b10001 for 3 cycles → `pc`, `ir` unchanged.
